// File: rtl/branch_flag_unit_pkg.sv
// Shared control-path types for the CPU front end: branch kinds, condition
// codes, NZCV bit positions and the sequential PC increment.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        BT_NONE  = 3'd0,
        BT_B     = 3'd1,
        BT_BL    = 3'd2,
        BT_BCOND = 3'd3,
        BT_CBZ   = 3'd4,
        BT_CBNZ  = 3'd5,
        BT_BR    = 3'd6,
        BT_RSVD  = 3'd7
    } branch_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1,
        COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5,
        COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9,
        COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD,
        COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/branch_flag_unit_cond_eval.sv
// Combinational ARM condition evaluator: condition code + NZCV -> pass bit.
// Kept standalone so conditional-select instructions can reuse it.
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    logic base;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Codes come in true/inverted pairs selected by cond[0]; NV is the one
    // odd code that does not invert AL.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        pass = base ^ (cond[0] & (cond[3:1] != 3'd7));
    end

endmodule

// File: rtl/branch_flag_unit.sv
// NZCV flag register, branch resolution and program counter for the
// single-cycle CPU; redirect is decided combinationally and lands on pc next edge.
module branch_flag_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              set_flags,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    input  logic [2:0]        branch_type,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] imm_offset,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags_q,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] link_value,
    output logic              link_we
);

    branch_type_e             bt;
    logic                     cond_pass;
    logic [3:0]               flags_next;
    logic signed [ADDR_W-1:0] imm_s;
    logic [ADDR_W-1:0]        seq_pc;
    logic [ADDR_W-1:0]        rel_pc;
    logic [ADDR_W-1:0]        next_pc;

    assign bt = branch_type_e'(branch_type);

    // B.cond reads only the registered flags, never this cycle's ALU result.
    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    always_comb begin
        branch_taken = 1'b0;
        case (bt)
            BT_B, BT_BL, BT_BR: branch_taken = 1'b1;
            BT_BCOND:           branch_taken = cond_pass;
            BT_CBZ:             branch_taken = alu_zero;
            BT_CBNZ:            branch_taken = ~alu_zero;
            default:            branch_taken = 1'b0;
        endcase
    end

    assign imm_s  = signed'(imm_offset);
    assign seq_pc = pc + ADDR_W'(PC_INCR);
    assign rel_pc = pc + unsigned'(imm_s <<< 2);

    always_comb begin
        next_pc = seq_pc;
        if (branch_taken) begin
            next_pc = (bt == BT_BR) ? br_target : rel_pc;
        end
    end

    assign link_value = seq_pc;
    assign link_we    = (bt == BT_BL) & ~stall;

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_N] = alu_negative;
        flags_next[FLAG_Z] = alu_zero;
        flags_next[FLAG_C] = alu_carry_out;
        flags_next[FLAG_V] = alu_overflow;
    end

    // Architectural state boundary: pc and flags_q advance together unless stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            flags_q <= 4'b0000;
        end else if (!stall) begin
            pc <= next_pc;
            if (set_flags) begin
                flags_q <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit with a cycle-by-cycle reference model.
module tb_branch_flag_unit;

    localparam int          AW  = 64;
    localparam logic [63:0] RPC = 64'h0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall;
    logic          set_flags;
    logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic [2:0]    branch_type;
    logic [3:0]    cond;
    logic [AW-1:0] imm_offset;
    logic [AW-1:0] br_target;
    logic [AW-1:0] pc;
    logic [3:0]    flags_q;
    logic          branch_taken;
    logic [AW-1:0] link_value;
    logic          link_we;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [63:0] pc_m;
    logic [3:0]  flags_m;

    branch_flag_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .set_flags     (set_flags),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .branch_type   (branch_type),
        .cond          (cond),
        .imm_offset    (imm_offset),
        .br_target     (br_target),
        .pc            (pc),
        .flags_q       (flags_q),
        .branch_taken  (branch_taken),
        .link_value    (link_value),
        .link_we       (link_we)
    );

    always #5 clk = ~clk;

    // Truth table written out literally, flags given as {N,Z,C,V}.
    function automatic logic m_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !(cy && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] bt, input logic [3:0] f,
                                     input logic [3:0] c, input logic az);
        case (bt)
            3'd1, 3'd2, 3'd6: return 1'b1;
            3'd3:             return m_cond(f, c);
            3'd4:             return az;
            3'd5:             return !az;
            default:          return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_m    <= RPC;
            flags_m <= 4'b0000;
        end else if (!stall) begin
            if (!m_taken(branch_type, flags_m, cond, alu_zero))
                pc_m <= pc_m + 64'd4;
            else if (branch_type == 3'd6)
                pc_m <= br_target;
            else
                pc_m <= pc_m + imm_offset * 64'd4;
            if (set_flags)
                flags_m <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_pc", pc, pc_m);
            chk("cmp_flags", {60'd0, flags_q}, {60'd0, flags_m});
            chk("cmp_taken", {63'd0, branch_taken},
                {63'd0, m_taken(branch_type, flags_m, cond, alu_zero)});
            chk("cmp_link_value", link_value, pc_m + 64'd4);
            chk("cmp_link_we", {63'd0, link_we},
                {63'd0, (branch_type == 3'd2) && !stall});
        end
    end

    task automatic idle();
        stall = 0; set_flags = 0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        branch_type = 3'd0; cond = 4'h0; imm_offset = '0; br_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [63:0] t);
        idle();
        branch_type = 3'd6; br_target = t;
        step();
        idle();
    endtask

    logic [63:0] pc_hold;
    logic [3:0]  fl_hold;

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        chk("reset_pc", pc, 64'h0);
        chk("reset_flags", {60'd0, flags_q}, 64'h0);
        reset_n = 1'b1;
        check_en = 1'b1;
        step(); chk("seq_pc4", pc, 64'h4);
        step(); chk("seq_pc8", pc, 64'h8);
        step(); chk("seq_pc12", pc, 64'hC);

        // SUBS then B.GT, taken
        jump_to(64'h3C);
        set_flags = 1; alu_carry_out = 1;
        step(); idle();
        chk("subs_flags", {60'd0, flags_q}, 64'h2);
        chk("subs_pc", pc, 64'h40);
        branch_type = 3'd3; cond = 4'hC; imm_offset = -64'd3;
        #1 chk("gt_taken", {63'd0, branch_taken}, 64'h1);
        step(); idle();
        chk("gt_pc", pc, 64'h34);

        // Same with Z=1, not taken
        jump_to(64'h3C);
        set_flags = 1; alu_carry_out = 1; alu_zero = 1;
        step(); idle();
        chk("subs_z_flags", {60'd0, flags_q}, 64'h6);
        branch_type = 3'd3; cond = 4'hC; imm_offset = -64'd3;
        #1 chk("gt_not_taken", {63'd0, branch_taken}, 64'h0);
        step(); idle();
        chk("gt_nt_pc", pc, 64'h44);

        // Flags set in the same cycle as B.cond: old flags decide (Z=1 -> EQ taken)
        branch_type = 3'd3; cond = 4'h0; imm_offset = 64'd2;
        set_flags = 1; alu_zero = 0;
        step(); idle();
        chk("same_cycle_pc", pc, 64'h4C);
        chk("same_cycle_flags", {60'd0, flags_q}, 64'h0);

        // CBZ / CBNZ
        jump_to(64'h100);
        branch_type = 3'd4; alu_zero = 1; imm_offset = 64'd5;
        step(); idle();
        chk("cbz_pc", pc, 64'h114);
        jump_to(64'h100);
        branch_type = 3'd5; alu_zero = 1; imm_offset = 64'd5;
        step(); idle();
        chk("cbnz_pc", pc, 64'h104);

        // BL then BR back
        jump_to(64'h200);
        branch_type = 3'd2; imm_offset = 64'h10;
        #1;
        chk("bl_link_we", {63'd0, link_we}, 64'h1);
        chk("bl_link_value", link_value, 64'h204);
        step(); idle();
        chk("bl_pc", pc, 64'h240);
        jump_to(64'h204);
        chk("br_pc", pc, 64'h204);
        jump_to(64'h1003);
        chk("br_misaligned_pc", pc, 64'h1003);

        // Wrap-around
        jump_to(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc", pc, 64'h0);

        // Stall freezes everything
        pc_hold = pc; fl_hold = flags_q;
        stall = 1; set_flags = 1; branch_type = 3'd2; imm_offset = 64'h10;
        alu_negative = 1; alu_zero = 1; alu_carry_out = 1; alu_overflow = 1;
        #1 chk("stall_link_we", {63'd0, link_we}, 64'h0);
        step();
        chk("stall_pc", pc, pc_hold);
        chk("stall_flags", {60'd0, flags_q}, {60'd0, fl_hold});
        idle();

        // Full condition sweep
        for (int f = 0; f < 16; f++) begin
            idle();
            set_flags = 1;
            {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'(f);
            step();
            idle();
            stall = 1; branch_type = 3'd3;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1 chk("sweep", {63'd0, branch_taken}, {63'd0, m_cond(4'(f), 4'(c))});
            end
        end
        idle();
        chk("sweep_last_flags", {60'd0, flags_q}, 64'hF);

        // Asynchronous reset between edges
        jump_to(64'h500);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_pc", pc, RPC);
        chk("async_reset_flags", {60'd0, flags_q}, 64'h0);
        #2 reset_n = 1'b1;
        step();
        chk("post_reset_pc", pc, 64'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
